// File: rtl/remote_comm.sv
// remote_comm: full-duplex UART (8N1) link to a robot.
// The transmitter sends a captured 16-bit command as two back-to-back bytes,
// high byte first. The receiver delivers one response byte at a time.
// Optional build macro REMOTE_COMM_FRAME_ERR_EN: when defined, a received
// frame whose stop bit is 0 is dropped, and the receiver waits for RX high.
module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  localparam logic [11:0] BIT_LAST  = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, TX_HIGH, TX_LOW} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

  tx_state_e   tx_state_q, tx_state_d;
  logic [11:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [15:0] hold_q, hold_d;
  logic        tx_q, tx_d;
  logic        cmd_snt_q, cmd_snt_d;
  logic [7:0]  cur_byte;
  logic [3:0]  next_bit;
  logic        accept;

  rx_state_e   rx_state_q, rx_state_d;
  logic [11:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        rx_done_q, rx_done_d;
  logic [7:0]  resp_q, resp_d;
  logic        resp_rdy_q, resp_rdy_d;
  logic        rx_s1_q, rx_s2_q, rx_s3_q;
  logic        rx_fall;
  logic        start_seen;

  assign accept  = snd_cmd && (tx_state_q == IDLE);
  assign rx_fall = rx_s3_q & ~rx_s2_q;

  assign TX       = tx_q;
  assign cmd_snt  = cmd_snt_q;
  assign resp_rdy = resp_rdy_q;
  assign resp     = resp_q;

  // Transmit next-state: bit timing, bit sequencing and the high/low byte handoff.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    hold_d     = hold_q;
    tx_d       = tx_q;
    cmd_snt_d  = cmd_snt_q;
    cur_byte   = (tx_state_q == TX_HIGH) ? hold_q[15:8] : hold_q[7:0];
    next_bit   = tx_bit_q + 4'd1;
    unique case (tx_state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (snd_cmd) begin
          hold_d     = cmd;
          tx_state_d = TX_HIGH;
          tx_cnt_d   = 12'd0;
          tx_bit_d   = 4'd0;
          tx_d       = 1'b0;
          cmd_snt_d  = 1'b0;
        end
      end
      TX_HIGH, TX_LOW: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = 12'd0;
          if (tx_bit_q == 4'd9) begin
            tx_bit_d = 4'd0;
            if (tx_state_q == TX_HIGH) begin
              tx_state_d = TX_LOW;
              tx_d       = 1'b0;
            end else begin
              tx_state_d = IDLE;
              tx_d       = 1'b1;
              cmd_snt_d  = 1'b1;
            end
          end else begin
            tx_bit_d = next_bit;
            tx_d     = (next_bit == 4'd9) ? 1'b1 : cur_byte[tx_bit_q[2:0]];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 12'd1;
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  // Transmit registers; reset aborts any frame and returns the line high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= 12'd0;
      tx_bit_q   <= 4'd0;
      hold_q     <= 16'h0000;
      tx_q       <= 1'b1;
      cmd_snt_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      hold_q     <= hold_d;
      tx_q       <= tx_d;
      cmd_snt_q  <= cmd_snt_d;
    end
  end

  // Receive next-state: start detection, mid-bit sampling and response delivery.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    shift_d    = shift_q;
    rx_done_d  = 1'b0;
    resp_d     = resp_q;
    resp_rdy_d = resp_rdy_q;
    start_seen = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_cnt_d   = 12'd0;
          start_seen = 1'b1;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = 12'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 12'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = 12'd0;
          shift_d  = {rx_s2_q, shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 12'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = 12'd0;
`ifdef REMOTE_COMM_FRAME_ERR_EN
          if (rx_s2_q) begin
            rx_done_d  = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_WAIT;
          end
`else
          rx_done_d  = 1'b1;
          rx_state_d = RX_IDLE;
`endif
        end else begin
          rx_cnt_d = rx_cnt_q + 12'd1;
        end
      end
      RX_WAIT: begin
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (rx_done_q) begin
      resp_d     = shift_q;
      resp_rdy_d = 1'b1;
    end else if (accept || start_seen) begin
      resp_rdy_d = 1'b0;
    end
  end

  // Receive registers plus RX synchronizer, preset high so reset release is quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 12'd0;
      rx_bit_q   <= 3'd0;
      shift_q    <= 8'h00;
      rx_done_q  <= 1'b0;
      resp_q     <= 8'h00;
      resp_rdy_q <= 1'b0;
    end else begin
      rx_s1_q    <= RX;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      shift_q    <= shift_d;
      rx_done_q  <= rx_done_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
    end
  end

endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: directed plus randomized checks of remote_comm at BAUD_DIV=16.
`timescale 1ns/1ps
module tb_remote_comm;

  localparam int DIV = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd = 16'h0000;
  logic        snd_cmd = 1'b0;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int tx_low_cycles = 0;
  int stop_err = 0;
  int busy_until = 0;
  int exp_snt_cycle = 0;
  logic [7:0] got_q[$];
  int         start_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_resp = 8'h00;
  logic       exp_rdy = 1'b0;

  remote_comm #(.BAUD_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .RX       (RX),
    .TX       (TX),
    .cmd      (cmd),
    .snd_cmd  (snd_cmd),
    .cmd_snt  (cmd_snt),
    .resp_rdy (resp_rdy),
    .resp     (resp)
  );

  always #5 clk = ~clk;

  // Cycle index: value seen at a negedge is the number of the preceding rising edge.
  always @(posedge clk) cycle <= cycle + 1;

  // Counts every cycle the TX line is low, used to prove the line stays quiet.
  always @(negedge clk) if (TX === 1'b0) tx_low_cycles++;

  // Decodes TX frames by mid-bit sampling and records the first cycle of each start bit.
  initial begin : tx_monitor
    logic [7:0] b;
    int sc;
    forever begin
      @(negedge clk);
      if (!rst && TX === 1'b0) begin
        sc = cycle;
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = TX;
        end
        repeat (DIV) @(negedge clk);
        if (TX !== 1'b1) stop_err++;
        got_q.push_back(b);
        start_q.push_back(sc);
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues a one-cycle request; the model accepts only when no command is in flight.
  task automatic send_cmd(input logic [15:0] c);
    @(negedge clk);
    cmd = c;
    snd_cmd = 1'b1;
    if (cycle >= busy_until) begin
      exp_q.push_back(c[15:8]);
      exp_q.push_back(c[7:0]);
      busy_until = cycle + 1 + 20 * DIV;
      exp_snt_cycle = busy_until;
      exp_rdy = 1'b0;
    end
    @(negedge clk);
    snd_cmd = 1'b0;
    cmd = ~c;
  endtask

  task automatic wait_cmd_snt(input string tag);
    int n = 0;
    while (cmd_snt !== 1'b1 && n < 30 * DIV) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_snt_cycle"}, 32'(cycle), 32'(exp_snt_cycle));
  endtask

  task automatic check_bytes(input string tag);
    check_output({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check_output({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
    start_q.delete();
  endtask

  task automatic drive_rx_head(input logic [7:0] b);
    RX = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic drive_rx_stop(input logic s);
    RX = s;
    repeat (DIV) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic check_resp(input string tag);
    check_output({tag, "_resp"}, 32'(resp), 32'(exp_resp));
    check_output({tag, "_rdy"}, 32'(resp_rdy), 32'(exp_rdy));
  endtask

  initial begin : stimulus
    logic [15:0] c;
    logic [7:0]  rb;
    int          snap;

    repeat (3) @(negedge clk);
    check_output("rst_tx", 32'(TX), 32'd1);
    check_output("rst_snt", 32'(cmd_snt), 32'd0);
    check_resp("rst");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_output("idle_tx", 32'(TX), 32'd1);

    // First command, with a second request arriving mid-frame that must be ignored.
    send_cmd(16'hA5C3);
    check_output("tx_start_bit", 32'(TX), 32'd0);
    check_output("snt_cleared", 32'(cmd_snt), 32'd0);
    snap = cycle;
    repeat (100) @(negedge clk);
    send_cmd(16'h1234);
    wait_cmd_snt("cmd1");
    check_output("nstarts", 32'(start_q.size()), 32'd2);
    if (start_q.size() >= 2) begin
      check_output("first_start", 32'(start_q[0]), 32'(snap));
      check_output("back_to_back", 32'(start_q[1] - start_q[0]), 32'(10 * DIV));
    end
    check_bytes("cmd1");
    repeat (20) @(negedge clk);
    check_output("snt_held", 32'(cmd_snt), 32'd1);

    // Request after completion is accepted and drops cmd_snt.
    send_cmd(16'h1234);
    check_output("snt_drop", 32'(cmd_snt), 32'd0);
    wait_cmd_snt("cmd2");
    check_bytes("cmd2");

    // Randomized commands.
    for (int k = 0; k < 3; k++) begin
      c = 16'($urandom);
      send_cmd(c);
      wait_cmd_snt("rand_cmd");
      check_bytes("rand_cmd");
    end

    // Valid response 0xA5; ready must not appear before the stop bit.
    drive_rx_head(8'hA5);
    check_output("rx_rdy_early", 32'(resp_rdy), 32'd0);
    drive_rx_stop(1'b1);
    exp_resp = 8'hA5;
    exp_rdy = 1'b1;
    check_resp("rx_a5");
    repeat (4) @(negedge clk);
    send_cmd(16'($urandom));
    check_resp("rx_clr_by_cmd");
    wait_cmd_snt("rx_clr");
    check_bytes("rx_clr");

    // Randomized response bytes.
    for (int k = 0; k < 3; k++) begin
      rb = 8'($urandom);
      drive_rx_head(rb);
      drive_rx_stop(1'b1);
      exp_resp = rb;
      exp_rdy = 1'b1;
      check_resp("rx_rand");
      repeat (4) @(negedge clk);
    end

    // Clear ready, then a short glitch must not produce a byte.
    send_cmd(16'h0F0F);
    wait_cmd_snt("pre_glitch");
    check_bytes("pre_glitch");
    RX = 1'b0;
    repeat (4) @(negedge clk);
    RX = 1'b1;
    repeat (40) @(negedge clk);
    check_resp("glitch");

    // Frame with a bad stop bit.
    drive_rx_head(8'h3C);
    drive_rx_stop(1'b0);
    repeat (6) @(negedge clk);
`ifndef REMOTE_COMM_FRAME_ERR_EN
    exp_resp = 8'h3C;
    exp_rdy = 1'b1;
`endif
    check_resp("frame_err");

    // Receiver re-arms after the bad frame.
    rb = 8'($urandom);
    drive_rx_head(rb);
    drive_rx_stop(1'b1);
    exp_resp = rb;
    exp_rdy = 1'b1;
    check_resp("rearm");
    repeat (4) @(negedge clk);

    // Full duplex: transmit and receive at the same time.
    c = 16'($urandom);
    rb = 8'($urandom);
    fork
      begin
        send_cmd(c);
        wait_cmd_snt("duplex");
      end
      begin
        repeat (3) @(negedge clk);
        drive_rx_head(rb);
        drive_rx_stop(1'b1);
        exp_resp = rb;
        exp_rdy = 1'b1;
      end
    join
    check_resp("duplex");
    check_bytes("duplex");
    check_output("tx_stop_bits", 32'(stop_err), 32'd0);

    // Reset in the middle of a transmission.
    send_cmd(16'hA5C3);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("midrst_tx", 32'(TX), 32'd1);
    check_output("midrst_snt", 32'(cmd_snt), 32'd0);
    exp_resp = 8'h00;
    exp_rdy = 1'b0;
    check_resp("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    snap = tx_low_cycles;
    repeat (400) @(negedge clk);
    check_output("post_rst_quiet", 32'(tx_low_cycles), 32'(snap));
    check_output("post_rst_snt", 32'(cmd_snt), 32'd0);
    got_q.delete();
    start_q.delete();
    exp_q.delete();
    busy_until = 0;

    // Link works again after reset.
    send_cmd(16'hBEEF);
    wait_cmd_snt("post_rst");
    check_bytes("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/remote_comm.md
REMOTE_COMM -- requirements
Module: remote_comm

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 2604, clocks per UART bit (19200 baud at 50 MHz); legal range 16..4095.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port RX  input  1  UART serial in (response from robot), idle high.
REQ-005 SHALL have port TX  output  1  UART serial out (command to robot), idle high.
REQ-006 SHALL have port cmd  input  16  command word to send.
REQ-007 SHALL have port snd_cmd  input  1  one-cycle request to send cmd.
REQ-008 SHALL have port cmd_snt  output  1  both command bytes fully transmitted.
REQ-009 SHALL have port resp_rdy  output  1  response byte available.
REQ-010 SHALL have port resp  output  8  last received response byte.

Function
REQ-011 SHALL frame each byte UART 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each bit exactly BAUD_DIV clocks.
REQ-012 SHALL, on snd_cmd in state IDLE, capture cmd into a 16-bit holding register in that cycle; later cmd changes have no effect.
REQ-013 SHALL use send FSM IDLE -> TX_HIGH (send cmd[15:8]) -> TX_LOW (send cmd[7:0]) -> IDLE, with no idle gap between the two frames (low-byte start bit follows high-byte stop bit on the next bit boundary).
REQ-014 SHALL assert TX start bit within 2 clocks of accepting snd_cmd.
REQ-015 SHALL ignore snd_cmd while in TX_HIGH or TX_LOW (no re-capture, no restart).
REQ-016 SHALL clear cmd_snt on the cycle snd_cmd is accepted, set it the cycle after the low byte's stop bit completes, and hold it until the next accepted snd_cmd.
REQ-017 SHALL double-flop RX before use; the receiver detects a start bit on a synchronized falling edge while idle.
REQ-018 SHALL sample each RX bit at BAUD_DIV/2 clocks into the bit (start bit re-checked at mid-bit; if high, treat as glitch and return to idle).
REQ-019 SHALL load resp and set resp_rdy one clock after the stop-bit sample; resp holds until the next valid byte.
REQ-020 SHALL clear resp_rdy on an accepted snd_cmd or on detection of the next start bit; if a byte completes in the same cycle snd_cmd is accepted, set wins.
REQ-021 SHALL operate transmitter and receiver independently and concurrently (full duplex).

Reset
REQ-022 SHALL, while rst is high, force TX=1, cmd_snt=0, resp_rdy=0, resp=8'h00, send FSM=IDLE, receiver idle, all counters 0.
REQ-023 SHALL abort any frame in progress on reset with TX returning high immediately; no partial byte completes after release.
REQ-024 SHALL preset the RX synchronizer flops to 1 on reset so release with RX idle produces no false start.

Configuration
REQ-025 SHALL honour macro REMOTE_COMM_FRAME_ERR_EN: when defined, a received frame whose stop-bit sample is 0 is discarded (resp and resp_rdy unchanged) and the receiver waits for RX high before re-arming; when undefined, every frame is accepted regardless of stop bit.

Verification (BAUD_DIV=16 unless noted)
REQ-026 SHALL pass: reset, snd_cmd with cmd=16'hA5C3 -> TX shows frames 0xA5 then 0xC3, LSB first, 160 bit-clocks each, back to back; cmd_snt rises once after 320 clocks and stays high.
REQ-027 SHALL pass: second snd_cmd (cmd=16'h1234) issued mid-frame of the first -> ignored, only 0xA5,0xC3 appear; issued after cmd_snt -> cmd_snt drops and 0x12,0x34 follow.
REQ-028 SHALL pass: drive RX with valid frame 0xA5 -> resp=8'hA5, resp_rdy=1 within 1 clock after stop-bit sample; next snd_cmd clears resp_rdy.
REQ-029 SHALL pass: 4-clock low glitch on idle RX -> no reception, resp_rdy stays 0.
REQ-030 SHALL pass: rst pulsed mid-transmission of 0xA5 -> TX high, cmd_snt=0, resp_rdy=0, resp=0 immediately and no further TX activity.
REQ-031 SHALL pass: with REMOTE_COMM_FRAME_ERR_EN defined, RX frame 0x3C with stop bit 0 -> resp_rdy stays 0, resp unchanged; without macro -> resp=8'h3C, resp_rdy=1.
